// File: rtl/pipe_sub64.sv
// pipe_sub64: pipelined 64-bit two's-complement subtractor, DIFF = A - B.
//
// The difference is formed as A + ~B + 1 by four 16-bit carry-lookahead slices. Each slice's
// carry is registered before the next slice uses it, so the critical path is one 16-bit CLA.
// The pipeline has an operand-capture rank followed by four stage ranks:
//   op rank  : A/B[63:0] as accepted
//   rank 1   : A/B[63:16], DIFF[15:0],  carry out of bit 15
//   rank 2   : A/B[63:32], DIFF[31:0],  carry out of bit 31
//   rank 3   : A/B[63:48], DIFF[47:0],  carry out of bit 47
//   out rank : DIFF[63:0], BORROW, OVF
// Stage k reads rank k and writes rank k+1. Its valid bit is v_k (stage_valid_q[k]), and
// out_valid = v3. An operand accepted at one edge is presented four edges later.
//
// Flow control is a single global stall: when the output holds a result the consumer
// does not take, nothing in the pipeline moves and no new operand is accepted.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   A/B present this cycle
//   in_ready   block accepts A/B this cycle
//   A, B       minuend, subtrahend
//   out_valid  DIFF/BORROW/OVF valid
//   out_ready  consumer accepts the result this cycle
//   DIFF       A - B mod 2^64
//   BORROW     1 when A < B unsigned
//   OVF        signed overflow of A - B
module pipe_sub64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] DIFF,
  output logic        BORROW,
  output logic        OVF
);

  // 16-bit carry-lookahead adder. Returns {carry_out, sum}.
  // Bit generate/propagate feed four 4-bit groups; group carries come from a
  // second lookahead level, then each group resolves its internal carries.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {gc[4], p ^ c};
  endfunction

  // Flow control
  logic stall;
  logic advance;

  // Operand-capture rank
  logic        op_valid_q, op_valid_d;
  logic [63:0] op_a_q, op_a_d;
  logic [63:0] op_b_q, op_b_d;

  // Stage valid bits v0..v3
  logic [3:0]  stage_valid_q, stage_valid_d;

  // Rank 1: after slice 0
  logic [63:16] r1_a_q, r1_a_d;
  logic [63:16] r1_b_q, r1_b_d;
  logic [15:0]  r1_diff_q, r1_diff_d;
  logic         r1_c_q, r1_c_d;

  // Rank 2: after slice 1
  logic [63:32] r2_a_q, r2_a_d;
  logic [63:32] r2_b_q, r2_b_d;
  logic [31:0]  r2_diff_q, r2_diff_d;
  logic         r2_c_q, r2_c_d;

  // Rank 3: after slice 2
  logic [63:48] r3_a_q, r3_a_d;
  logic [63:48] r3_b_q, r3_b_d;
  logic [47:0]  r3_diff_q, r3_diff_d;
  logic         r3_c_q, r3_c_d;

  // Output rank
  logic [63:0] diff_q, diff_d;
  logic        borrow_q, borrow_d;
  logic        ovf_q, ovf_d;

  // Slice results {carry_out, sum}
  logic [16:0] s0_sum;
  logic [16:0] s1_sum;
  logic [16:0] s2_sum;
  logic [16:0] s3_sum;

  // Stall depends only on the output rank and out_ready, never on in_valid.
  assign stall     = stage_valid_q[3] & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = stage_valid_q[3];
  assign DIFF      = diff_q;
  assign BORROW    = borrow_q;
  assign OVF       = ovf_q;

  // One CLA slice per stage; subtrahend inverted, initial carry-in of 1 completes ~B + 1.
  always_comb begin
    s0_sum = cla16(op_a_q[15:0],  ~op_b_q[15:0],  1'b1);
    s1_sum = cla16(r1_a_q[31:16], ~r1_b_q[31:16], r1_c_q);
    s2_sum = cla16(r2_a_q[47:32], ~r2_b_q[47:32], r2_c_q);
    s3_sum = cla16(r3_a_q[63:48], ~r3_b_q[63:48], r3_c_q);
  end

  always_comb begin
    op_valid_d    = op_valid_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    stage_valid_d = stage_valid_q;
    r1_a_d        = r1_a_q;
    r1_b_d        = r1_b_q;
    r1_diff_d     = r1_diff_q;
    r1_c_d        = r1_c_q;
    r2_a_d        = r2_a_q;
    r2_b_d        = r2_b_q;
    r2_diff_d     = r2_diff_q;
    r2_c_d        = r2_c_q;
    r3_a_d        = r3_a_q;
    r3_b_d        = r3_b_q;
    r3_diff_d     = r3_diff_q;
    r3_c_d        = r3_c_q;
    diff_d        = diff_q;
    borrow_d      = borrow_q;
    ovf_d         = ovf_q;

    if (advance) begin
      op_valid_d    = in_valid;
      stage_valid_d = {stage_valid_q[2:0], op_valid_q};

      // Operands are captured only on an accepting edge.
      if (in_valid) begin
        op_a_d = A;
        op_b_d = B;
      end

      // Data moves only behind a valid token; bubbles leave ranks untouched.
      if (op_valid_q) begin
        r1_a_d    = op_a_q[63:16];
        r1_b_d    = op_b_q[63:16];
        r1_diff_d = s0_sum[15:0];
        r1_c_d    = s0_sum[16];
      end

      if (stage_valid_q[0]) begin
        r2_a_d    = r1_a_q[63:32];
        r2_b_d    = r1_b_q[63:32];
        r2_diff_d = {s1_sum[15:0], r1_diff_q};
        r2_c_d    = s1_sum[16];
      end

      if (stage_valid_q[1]) begin
        r3_a_d    = r2_a_q[63:48];
        r3_b_d    = r2_b_q[63:48];
        r3_diff_d = {s2_sum[15:0], r2_diff_q};
        r3_c_d    = s2_sum[16];
      end

      if (stage_valid_q[2]) begin
        diff_d   = {s3_sum[15:0], r3_diff_q};
        // Carry out of A + ~B + 1 is set when no borrow occurred.
        borrow_d = ~s3_sum[16];
        // Operand signs differ and the result sign departs from the minuend's.
        ovf_d    = (r3_a_q[63] ^ r3_b_q[63]) & (s3_sum[15] ^ r3_a_q[63]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q    <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      stage_valid_q <= '0;
      r1_a_q        <= '0;
      r1_b_q        <= '0;
      r1_diff_q     <= '0;
      r1_c_q        <= 1'b0;
      r2_a_q        <= '0;
      r2_b_q        <= '0;
      r2_diff_q     <= '0;
      r2_c_q        <= 1'b0;
      r3_a_q        <= '0;
      r3_b_q        <= '0;
      r3_diff_q     <= '0;
      r3_c_q        <= 1'b0;
      diff_q        <= '0;
      borrow_q      <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      op_valid_q    <= op_valid_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      stage_valid_q <= stage_valid_d;
      r1_a_q        <= r1_a_d;
      r1_b_q        <= r1_b_d;
      r1_diff_q     <= r1_diff_d;
      r1_c_q        <= r1_c_d;
      r2_a_q        <= r2_a_d;
      r2_b_q        <= r2_b_d;
      r2_diff_q     <= r2_diff_d;
      r2_c_q        <= r2_c_d;
      r3_a_q        <= r3_a_d;
      r3_b_q        <= r3_b_d;
      r3_diff_q     <= r3_diff_d;
      r3_c_q        <= r3_c_d;
      diff_q        <= diff_d;
      borrow_q      <= borrow_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_sub64.sv
// Self-checking bench for pipe_sub64: directed corner cases, backpressure, mid-flight
// reset and a randomized run scored against a queue-based arithmetic model.
module tb_pipe_sub64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] DIFF;
  logic        BORROW;
  logic        OVF;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  // Expected results {ovf, borrow, diff} in acceptance order.
  logic [65:0] exp_q[$];

  pipe_sub64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DIFF      (DIFF),
    .BORROW    (BORROW),
    .OVF       (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Random operand biased toward sign and carry boundaries.
  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'h0000_0001_0000_0000;
      default: return rand64();
    endcase
  endfunction

  // Reference: plain unsigned/signed arithmetic on the whole 64-bit word.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] d;
    logic        bor;
    logic        ovf;
    d   = a - b;
    bor = (a < b);
    ovf = ($signed(a) < 0) != ($signed(b) < 0) && (($signed(d) < 0) != ($signed(a) < 0));
    return {ovf, bor, d};
  endfunction

  // Scoreboard: sample handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(A, B));
      if (out_valid && out_ready) begin
        logic [65:0] e;
        n_out++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_diff",   DIFF,        e[63:0]);
          check("sb_borrow", 64'(BORROW), 64'(e[64]));
          check("sb_ovf",    64'(OVF),    64'(e[65]));
        end
      end
    end
  end

  // One isolated operation: checks 4-cycle latency and the expected result.
  task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_d, input logic exp_bor, input logic exp_ovf);
    int lat;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    out_ready = 1'b1;
    @(posedge clk); #1;
    // Changing operands after acceptance must not affect the result.
    in_valid = 1'b0;
    A        = rand64();
    B        = rand64();
    lat      = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},    64'(lat),    64'd4);
    check({tag, "_diff"},   DIFF,        exp_d);
    check({tag, "_borrow"}, 64'(BORROW), 64'(exp_bor));
    check({tag, "_ovf"},    64'(OVF),    64'(exp_ovf));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] sa[8];
    logic [63:0] sb[8];
    logic [63:0] held;
    int          idx;
    int          stall_left;
    int          hold_chk;
    int          base;
    int          seen;
    int          guard;

    // Reset with in_valid asserted: nothing may be accepted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    A         = 64'h1234_5678_9ABC_DEF0;
    B         = 64'h0FED_CBA9_8765_4321;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff",      DIFF,           64'd0);
      check("rst_borrow",    64'(BORROW),    64'd0);
      check("rst_ovf",       64'(OVF),       64'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // Directed corners.
    run_one("basic", 64'h0000_0000_0000_0170, 64'h0000_0000_0000_0608,
            64'hFFFF_FFFF_FFFF_FB68, 1'b1, 1'b0);
    run_one("xslice", 64'h0000_0001_0000_0000, 64'h1,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run_one("zero_m1", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("ovf_neg", 64'h8000_0000_0000_0000, 64'h1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);

    // Back-to-back stream of 8 with a 3-cycle stall after the first result.
    for (int k = 0; k < 8; k++) begin
      sa[k] = pick64();
      sb[k] = pick64();
    end
    idx        = 0;
    stall_left = 0;
    hold_chk   = 0;
    seen       = 0;
    held       = '0;
    base       = n_out;
    out_ready  = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid && seen == 0) begin
        seen       = 1;
        stall_left = 3;
        hold_chk   = 3;
        held       = DIFF;
      end else if (hold_chk > 0) begin
        check("stall_hold", DIFF, held);
        hold_chk--;
      end
      out_ready = (stall_left == 0);
      if (idx < 8) begin
        in_valid = 1'b1;
        A        = sa[idx];
        B        = sb[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        stall_left--;
      end else begin
        check("flow_in_ready", 64'(in_ready), 64'd1);
      end
      if (in_valid && in_ready) idx++;
      if (idx == 8 && (n_out - base) >= 8) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", 64'(n_out - base), 64'd8);

    // Reset mid-flight: three accepted operations must vanish.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      A        = rand64();
      B        = rand64();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    run_one("post_rst", 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001,
            64'h0000_0000_0000_FFFF, 1'b0, 1'b0);

    // Randomized traffic with random backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = pick64();
      B         = pick64();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty",     64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid),    64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
